// File: rtl/hamming_pkg.sv
// Shared syndrome codes, decoder FSM state and parity helper for the Hamming block decoder.
// Parity per 4-bit block: p2 = d0^d2^d3, p1 = d0^d1^d3, p0 = d0^d1^d2.
package hamming_pkg;

  localparam logic [2:0] SYN_D0 = 3'b111;
  localparam logic [2:0] SYN_D1 = 3'b011;
  localparam logic [2:0] SYN_D2 = 3'b101;
  localparam logic [2:0] SYN_D3 = 3'b110;
  localparam logic [2:0] SYN_P0 = 3'b001;
  localparam logic [2:0] SYN_P1 = 3'b010;
  localparam logic [2:0] SYN_P2 = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [2:0] calc_parity(input logic [3:0] d);
    calc_parity = {d[0] ^ d[2] ^ d[3],
                   d[0] ^ d[1] ^ d[3],
                   d[0] ^ d[1] ^ d[2]};
  endfunction

endpackage

// File: rtl/hamming_lane.sv
// Combinational single-block decode: recomputes parity, forms the syndrome and
// corrects one flipped bit in either the 4 data bits or the 3 parity bits.
module hamming_lane
  import hamming_pkg::*;
(
  input  logic [3:0] d_in,
  input  logic [2:0] p_in,
  output logic [3:0] d_out,
  output logic [2:0] p_out,
  output logic       syn_nz,
  output logic       data_fix,
  output logic       par_fix
);

  logic [2:0] syn;

  always_comb begin
    syn      = calc_parity(d_in) ^ p_in;
    d_out    = d_in;
    p_out    = p_in;
    data_fix = 1'b0;
    par_fix  = 1'b0;
    // Two flipped bits alias onto a single-bit syndrome and get miscorrected.
    case (syn)
      SYN_D0: begin d_out[0] = ~d_in[0]; data_fix = 1'b1; end
      SYN_D1: begin d_out[1] = ~d_in[1]; data_fix = 1'b1; end
      SYN_D2: begin d_out[2] = ~d_in[2]; data_fix = 1'b1; end
      SYN_D3: begin d_out[3] = ~d_in[3]; data_fix = 1'b1; end
      SYN_P0: begin p_out[0] = ~p_in[0]; par_fix  = 1'b1; end
      SYN_P1: begin p_out[1] = ~p_in[1]; par_fix  = 1'b1; end
      SYN_P2: begin p_out[2] = ~p_in[2]; par_fix  = 1'b1; end
      default: ;
    endcase
    syn_nz = |syn;
  end

endmodule

// File: rtl/hamming_block_decoder.sv
// Time-multiplexed Hamming decoder: LANES blocks corrected per cycle, result held until out_ready.
// Optional HAMMING_DEC_STATS_EN adds stat_clr and saturating data/parity fix counters.
module hamming_block_decoder
  import hamming_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int LANES       = 4,
  parameter int CNT_W       = $clog2(BLOCKS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef HAMMING_DEC_STATS_EN
  input  logic                   stat_clr,
  output logic [15:0]            stat_data_fix,
  output logic [15:0]            stat_par_fix,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [PARITY_BITS-1:0] in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [PARITY_BITS-1:0] out_parity,
  output logic                   out_err,
  output logic [CNT_W-1:0]       out_corr_cnt
);

  localparam int GROUPS = BLOCKS / LANES;
  localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       work_data_q, work_data_d;
  logic [PARITY_BITS-1:0] work_par_q, work_par_d;

  logic [3:0]       lane_d_in  [LANES];
  logic [2:0]       lane_p_in  [LANES];
  logic [3:0]       lane_d_out [LANES];
  logic [2:0]       lane_p_out [LANES];
  logic [LANES-1:0] lane_nz;
  logic [LANES-1:0] lane_dfix;
  logic [LANES-1:0] lane_pfix;

  // Lane l always works on block idx*LANES + l of the current group.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_d_in[l] = work_data_q[(int'(idx_q) * LANES + l) * 4 +: 4];
      lane_p_in[l] = work_par_q[(int'(idx_q) * LANES + l) * 3 +: 3];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hamming_lane u_lane (
      .d_in     (lane_d_in[l]),
      .p_in     (lane_p_in[l]),
      .d_out    (lane_d_out[l]),
      .p_out    (lane_p_out[l]),
      .syn_nz   (lane_nz[l]),
      .data_fix (lane_dfix[l]),
      .par_fix  (lane_pfix[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      work_data_q <= '0;
      work_par_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      work_data_q <= work_data_d;
      work_par_q  <= work_par_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    work_data_d = work_data_q;
    work_par_d  = work_par_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_data_d = in_data;
          work_par_d  = in_parity;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        for (int l = 0; l < LANES; l++) begin
          work_data_d[(int'(idx_q) * LANES + l) * 4 +: 4] = lane_d_out[l];
          work_par_d[(int'(idx_q) * LANES + l) * 3 +: 3]  = lane_p_out[l];
          cnt_d = cnt_d + CNT_W'(lane_nz[l]);
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero outside DONE so a reset clears them at once.
  always_comb begin
    in_ready     = (state_q == IDLE) && !rst;
    out_valid    = (state_q == DONE);
    out_data     = out_valid ? work_data_q : '0;
    out_parity   = out_valid ? work_par_q  : '0;
    out_corr_cnt = out_valid ? cnt_q       : '0;
    out_err      = (out_corr_cnt != '0);
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [15:0] stat_data_q, stat_data_d;
  logic [15:0] stat_par_q, stat_par_d;
  logic [16:0] data_inc, par_inc, data_sum, par_sum;

  always_comb begin
    data_inc = '0;
    par_inc  = '0;
    for (int l = 0; l < LANES; l++) begin
      data_inc = data_inc + 17'(lane_dfix[l]);
      par_inc  = par_inc  + 17'(lane_pfix[l]);
    end
    data_sum    = {1'b0, stat_data_q} + data_inc;
    par_sum     = {1'b0, stat_par_q} + par_inc;
    stat_data_d = stat_data_q;
    stat_par_d  = stat_par_q;
    if (state_q == DECODE) begin
      stat_data_d = data_sum[16] ? 16'hFFFF : data_sum[15:0];
      stat_par_d  = par_sum[16]  ? 16'hFFFF : par_sum[15:0];
    end
    if (stat_clr) begin
      stat_data_d = '0;
      stat_par_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_data_q <= '0;
      stat_par_q  <= '0;
    end else begin
      stat_data_q <= stat_data_d;
      stat_par_q  <= stat_par_d;
    end
  end

  assign stat_data_fix = stat_data_q;
  assign stat_par_fix  = stat_par_q;
`else
  logic unused_fix;
  assign unused_fix = ^{lane_dfix, lane_pfix};
`endif

endmodule

// File: tb/tb_hamming_block_decoder.sv
// Directed bench for hamming_block_decoder: vector table plus backpressure, reset and stats sequences.
module tb_hamming_block_decoder;

  localparam int WIDTH = 64;
  localparam int PB    = 48;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [PB-1:0]    in_parity;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [PB-1:0]    out_parity;
  logic             out_err;
  logic [CNT_W-1:0] out_corr_cnt;
`ifdef HAMMING_DEC_STATS_EN
  logic             stat_clr;
  logic [15:0]      stat_data_fix;
  logic [15:0]      stat_par_fix;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_block_decoder dut (
    .clk          (clk),
    .rst          (rst),
`ifdef HAMMING_DEC_STATS_EN
    .stat_clr     (stat_clr),
    .stat_data_fix(stat_data_fix),
    .stat_par_fix (stat_par_fix),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_parity    (in_parity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_parity   (out_parity),
    .out_err      (out_err),
    .out_corr_cnt (out_corr_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [47:0] p;
    logic [63:0] ed;
    logic [47:0] ep;
    int          ec;
    logic        ee;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents one word and returns at the first falling edge with out_valid high.
  // lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic run_word(input logic [63:0] d, input logic [47:0] p,
                          input logic rdy, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    out_ready = rdy;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = ~d;
    in_parity = ~p;
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;

    vecs[0] = '{64'h1, 48'h7, 64'h1, 48'h7, 0, 1'b0};
    vecs[1] = '{64'h0, 48'h7, 64'h1, 48'h7, 1, 1'b1};
    vecs[2] = '{64'h0, 48'h10, 64'h0, 48'h0, 1, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 48'h0, 64'hEEEE_EEEE_EEEE_EEEE, 48'h0, 16, 1'b1};
    vecs[4] = '{64'h0, 48'h1, 64'h0, 48'h0, 1, 1'b1};
    vecs[5] = '{64'hD00, 48'h80, 64'h500, 48'h80, 1, 1'b1};
    vecs[6] = '{64'h0, 48'h8000_0000_0000, 64'h0, 48'h0, 1, 1'b1};
    vecs[7] = '{64'h0, 48'h3, 64'h2, 48'h3, 1, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 0, 1'b0};
    vecs[9] = '{64'h8000_0000_0000_0001, 48'h0, 64'h0, 48'h0, 2, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_parity = '0;
    out_ready = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
    stat_clr  = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_parity", 64'(out_parity), 64'd0);
    chk("rst_out_cnt", 64'(out_corr_cnt), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_word(vecs[i].d, vecs[i].p, 1'b1, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
      chk($sformatf("v%0d_parity", i), 64'(out_parity), 64'(vecs[i].ep));
      chk($sformatf("v%0d_cnt", i), 64'(out_corr_cnt), 64'(vecs[i].ec));
      chk($sformatf("v%0d_err", i), 64'(out_err), 64'(vecs[i].ee));
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), {62'd0, out_valid, in_ready}, 64'd1);
    end

    // Backpressure: result held, no new accept while DONE, even with in_valid high.
    run_word(64'h0, 48'h7, 1'b0, lat);
    chk("bp_latency", 64'(lat), 64'd5);
    in_valid  = 1'b1;
    in_data   = 64'hDEAD_BEEF_0123_4567;
    in_parity = 48'h1234_5678_9ABC;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_data", c), out_data, 64'h1);
      chk($sformatf("bp%0d_parity", c), 64'(out_parity), 64'h7);
      chk($sformatf("bp%0d_cnt", c), 64'(out_corr_cnt), 64'd1);
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

`ifdef HAMMING_DEC_STATS_EN
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_word(64'h0, 48'h7, 1'b1, lat);
    end
    run_word(64'h0, 48'h10, 1'b1, lat);
    chk("stat_data_fix", 64'(stat_data_fix), 64'd3);
    chk("stat_par_fix", 64'(stat_par_fix), 64'd1);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_clr_data", 64'(stat_data_fix), 64'd0);
    chk("stat_clr_par", 64'(stat_par_fix), 64'd0);
`endif

    // Reset in the middle of DECODE discards the partial word.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    in_parity = 48'h0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_cnt", 64'(out_corr_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    chk("post_rst_no_valid", 64'(out_valid), 64'd0);

    run_word(vecs[3].d, vecs[3].p, 1'b1, lat);
    chk("recover_latency", 64'(lat), 64'd5);
    chk("recover_data", out_data, vecs[3].ed);
    chk("recover_cnt", 64'(out_corr_cnt), 64'd16);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
